harvos_dmem_copy: RTL and testbench

HARVOS_DMEM_COPY -- requirements
Module: harvos_dmem_copy

---
 rtl/harvos_dmem_copy.sv | 126 ++++++++++++
 tb/tb_harvos_dmem_copy.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/harvos_dmem_copy.sv
// harvos_dmem_copy: word-by-word memory copy engine driving a single-outstanding data port
module harvos_dmem_copy #(
   parameter int unsigned TIMEOUT = 16,
   parameter int unsigned LEN_W   = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [31:0]      src_addr,
   input  logic [31:0]      dst_addr,
   input  logic [LEN_W-1:0] len_words,
   output logic             busy,
   output logic             done,
   output logic             err,
   output logic [LEN_W-1:0] words_done,
   output logic             dmem_req,
   output logic             dmem_we,
   output logic [3:0]       dmem_be,
   output logic [31:0]      dmem_addr,
   output logic [31:0]      dmem_wdata,
   input  logic             dmem_rvalid,
   input  logic             dmem_fault,
   input  logic [31:0]      dmem_rdata
);
   localparam int unsigned WAIT_W = $clog2(TIMEOUT + 1);
   typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, FIN} state_t;
   state_t            state_q, state_d;
   logic [31:0]       src_q, src_d, dst_q, dst_d, data_q, data_d;
   logic [LEN_W-1:0]  len_q, len_d, cnt_q, cnt_d;
   logic [WAIT_W-1:0] wait_q, wait_d;
   logic              err_q, err_d;
   logic              expired;
   assign expired    = wait_q == WAIT_W'(TIMEOUT - 1);
   assign words_done = cnt_q;
   assign err        = err_q;
   // Next-state: sequencing, address stepping, response wait and abort handling
   always_comb begin
      state_d = state_q;
      src_d   = src_q;
      dst_d   = dst_q;
      len_d   = len_q;
      data_d  = data_q;
      cnt_d   = cnt_q;
      wait_d  = wait_q;
      err_d   = 1'b0;
      case (state_q)
         IDLE, FIN: begin
            state_d = IDLE;
            if (start) begin
               src_d = src_addr;
               dst_d = dst_addr;
               len_d = len_words;
               cnt_d = '0;
               if (len_words == '0) state_d = FIN;
               else if (src_addr[1:0] != 2'b00 || dst_addr[1:0] != 2'b00) err_d = 1'b1;
               else state_d = RD_REQ;
            end
         end
         RD_REQ: begin
            wait_d  = '0;
            state_d = RD_WAIT;
         end
         RD_WAIT: begin
            if (dmem_rvalid) begin
               err_d   = dmem_fault;
               data_d  = dmem_fault ? data_q : dmem_rdata;
               state_d = dmem_fault ? IDLE : WR_REQ;
            end else if (expired) begin
               err_d   = 1'b1;
               state_d = IDLE;
            end else wait_d = wait_q + 1'b1;
         end
         WR_REQ: begin
            wait_d  = '0;
            state_d = WR_WAIT;
         end
         WR_WAIT: begin
            if (dmem_rvalid && dmem_fault) begin
               err_d   = 1'b1;
               state_d = IDLE;
            end else if (dmem_rvalid) begin
               cnt_d   = cnt_q + 1'b1;
               src_d   = src_q + 32'd4;
               dst_d   = dst_q + 32'd4;
               state_d = (cnt_d == len_q) ? FIN : RD_REQ;
            end else if (expired) begin
               err_d   = 1'b1;
               state_d = IDLE;
            end else wait_d = wait_q + 1'b1;
         end
         default: state_d = IDLE;
      endcase
   end
   // State and datapath registers; reset cancels any copy in flight
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         src_q   <= '0;
         dst_q   <= '0;
         len_q   <= '0;
         data_q  <= '0;
         cnt_q   <= '0;
         wait_q  <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         src_q   <= src_d;
         dst_q   <= dst_d;
         len_q   <= len_d;
         data_q  <= data_d;
         cnt_q   <= cnt_d;
         wait_q  <= wait_d;
         err_q   <= err_d;
      end
   end
   // Outputs decoded from state; the data port is fully zeroed when no request is issued
   always_comb begin
      busy       = state_q inside {RD_REQ, RD_WAIT, WR_REQ, WR_WAIT};
      done       = state_q == FIN;
      dmem_req   = state_q == RD_REQ || state_q == WR_REQ;
      dmem_we    = state_q == WR_REQ;
      dmem_be    = dmem_req ? 4'hF : 4'h0;
      dmem_addr  = state_q == RD_REQ ? src_q : state_q == WR_REQ ? dst_q : 32'h0;
      dmem_wdata = state_q == WR_REQ ? data_q : 32'h0;
   end
endmodule

// File: tb/tb_harvos_dmem_copy.sv
// tb_harvos_dmem_copy: randomized copy runs against a word-level memory reference model
module tb_harvos_dmem_copy;
   localparam int TO = 16;
   logic        clk, rst_n, start;
   logic [31:0] src_addr, dst_addr;
   logic [15:0] len_words;
   logic        busy, done, err;
   logic [15:0] words_done;
   logic        dmem_req, dmem_we;
   logic [3:0]  dmem_be;
   logic [31:0] dmem_addr, dmem_wdata;
   logic        dmem_rvalid, dmem_fault;
   logic [31:0] dmem_rdata;
   int n_vec = 0, n_bad = 0, cyc = 0;
   int n_req = 0, rd_n = 0, wr_n = 0, idle_bad = 0, both_bad = 0, be_bad = 0;
   int hold_at, fault_at;
   logic [31:0] mem [logic [31:0]];
   logic [31:0] ref_mem [logic [31:0]];
   logic [31:0] rd_q [$];
   bit          pend = 1'b0, p_we = 1'b0;
   logic [31:0] p_addr = 32'h0, p_wdata = 32'h0;

   harvos_dmem_copy #(.TIMEOUT(TO), .LEN_W(16)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .src_addr(src_addr), .dst_addr(dst_addr),
      .len_words(len_words), .busy(busy), .done(done), .err(err), .words_done(words_done),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_be(dmem_be), .dmem_addr(dmem_addr),
      .dmem_wdata(dmem_wdata), .dmem_rvalid(dmem_rvalid), .dmem_fault(dmem_fault),
      .dmem_rdata(dmem_rdata));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [31:0] init_word(input logic [31:0] a);
      return (a >= 32'h2000_0100 && a <= 32'h2000_010C) ? ((a - 32'h2000_0100) >> 2) + 32'd1
                                                         : {a[15:0] ^ 16'hC3A5, a[31:16]};
   endfunction
   function automatic logic [31:0] mget(input logic [31:0] a);
      return mem.exists(a) ? mem[a] : init_word(a);
   endfunction
   function automatic logic [31:0] rget(input logic [31:0] a);
      return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Responder with one-cycle latency; also watches data-port protocol on every cycle
   always @(negedge clk) begin
      dmem_rvalid = 1'b0;
      dmem_fault  = 1'b0;
      dmem_rdata  = 32'h0;
      if (!rst_n) pend = 1'b0;
      if (pend) begin
         pend = 1'b0;
         if (!p_we && rd_n != hold_at) begin
            dmem_rvalid = 1'b1;
            dmem_rdata  = mget(p_addr);
         end else if (p_we) begin
            dmem_rvalid = 1'b1;
            if (wr_n == fault_at) dmem_fault = 1'b1;
            else mem[p_addr] = p_wdata;
         end
      end
      if (rst_n && dmem_req) begin
         pend    = 1'b1;
         p_we    = dmem_we;
         p_addr  = dmem_addr;
         p_wdata = dmem_wdata;
         n_req++;
         if (dmem_we) wr_n++;
         else begin
            rd_n++;
            rd_q.push_back(dmem_addr);
         end
      end
      if (!dmem_req && (dmem_we || dmem_be != 4'h0 || dmem_addr != 32'h0 || dmem_wdata != 32'h0)) idle_bad++;
      if (dmem_req && dmem_be != 4'hF) be_bad++;
      if (done && err) both_bad++;
   end

   task automatic run(input logic [31:0] s, input logic [31:0] d, input int n, input int fw,
                      input bit hold, input string tag);
      int  base_req, t0, t_end, lat, wd, nreq;
      bit  mis, got_done, got_err, exp_done, to_case, f_case;
      mis     = n != 0 && (s[1:0] | d[1:0]) != 2'b00;
      to_case = n != 0 && !mis && hold;
      f_case  = n != 0 && !mis && !hold && fw >= 1 && fw <= n;
      if (n == 0)        begin exp_done = 1; lat = 1;          wd = 0;      nreq = 0;      end
      else if (mis)      begin exp_done = 0; lat = 1;          wd = 0;      nreq = 0;      end
      else if (to_case)  begin exp_done = 0; lat = 2 + TO;     wd = 0;      nreq = 1;      end
      else if (f_case)   begin exp_done = 0; lat = 4 * fw + 1; wd = fw - 1; nreq = 2 * fw; end
      else               begin exp_done = 1; lat = 4 * n + 1;  wd = n;      nreq = 2 * n;  end
      ref_mem = mem;
      for (int i = 0; i < wd; i++) ref_mem[d + 32'(4 * i)] = rget(s + 32'(4 * i));
      hold_at  = to_case ? rd_n + 1 : 0;
      fault_at = f_case ? wr_n + fw : 0;
      base_req = n_req;
      got_done = 1'b0;
      got_err  = 1'b0;
      t_end    = -1;
      @(negedge clk);
      start     = 1'b1;
      src_addr  = s;
      dst_addr  = d;
      len_words = 16'(n);
      t0        = cyc;
      for (int k = 0; k < 4 * n + 2 * TO + 8 && !(got_done || got_err); k++) begin
         @(negedge clk);
         start = busy ? 1'($urandom_range(0, 1)) : 1'b0;
         if (busy) begin
            src_addr  = $urandom;
            dst_addr  = $urandom;
            len_words = 16'($urandom);
         end
         got_done = done;
         got_err  = err;
         t_end    = cyc - t0;
      end
      start = 1'b0;
      check($sformatf("%s.outcome", tag), {got_done, got_err}, {exp_done, !exp_done});
      check($sformatf("%s.latency", tag), t_end, lat);
      check($sformatf("%s.words_done", tag), words_done, wd);
      check($sformatf("%s.requests", tag), n_req - base_req, nreq);
      check($sformatf("%s.busy_end", tag), busy, 0);
      if (n > 0 && !mis)
         for (int i = 0; i < n && i < 8; i++)
            check($sformatf("%s.mem[%0d]", tag, i), mget(d + 32'(4 * i)), rget(d + 32'(4 * i)));
      @(negedge clk);
      check($sformatf("%s.one_pulse", tag), {done, err}, 0);
   endtask

   initial begin
      int base, k, pulses, n, fw;
      bit hold;
      logic [31:0] s, d;
      rst_n = 1'b0; start = 1'b0; src_addr = 32'h0; dst_addr = 32'h0; len_words = 16'h0;
      hold_at = 0; fault_at = 0;
      repeat (2) @(negedge clk);
      check("reset.ctl", {busy, done, err, dmem_req, dmem_we, dmem_be, words_done}, 0);
      check("reset.addr", dmem_addr, 0);
      check("reset.wdata", dmem_wdata, 0);
      @(negedge clk);
      rst_n = 1'b1;
      run(32'h2000_0100, 32'h2000_0200, 4, 0, 0, "copy4");
      for (int i = 0; i < 4; i++) check("copy4.value", mget(32'h2000_0200 + 32'(4 * i)), i + 1);
      run(32'h2000_0100, 32'h2000_0300, 0, 0, 0, "len0");
      run(32'h2000_0102, 32'h2000_0300, 1, 0, 0, "mis_src");
      run(32'h2000_0100, 32'h2000_0301, 2, 0, 0, "mis_dst");
      run(32'h2000_0100, 32'h2000_0600, 4, 2, 0, "wfault");
      run(32'h2000_0100, 32'h2000_0700, 3, 0, 1, "timeout");
      base = rd_q.size();
      run(32'hFFFF_FFFC, 32'h2000_0800, 2, 0, 0, "wrap");
      check("wrap.rd2_addr", rd_q[base + 1], 32'h0);
      @(negedge clk);
      start = 1'b1; src_addr = 32'h2000_0100; dst_addr = 32'h2000_0900; len_words = 16'd3;
      @(negedge clk);
      start = 1'b0;
      k = 0;
      while (!dmem_we && k < 20) begin
         @(negedge clk);
         k++;
      end
      check("rst_mid.wr_seen", dmem_we, 1);
      @(negedge clk);
      #1 rst_n = 1'b0;
      #1;
      check("rst_mid.ctl", {busy, done, err, dmem_req, dmem_we, dmem_be, words_done}, 0);
      check("rst_mid.addr", dmem_addr, 0);
      check("rst_mid.wdata", dmem_wdata, 0);
      pulses = 0;
      repeat (3) begin
         @(negedge clk);
         pulses += int'(done | err);
      end
      check("rst_mid.pulses", pulses, 0);
      rst_n = 1'b1;
      run(32'h2000_0104, 32'h2000_0A00, 1, 0, 0, "after_rst");
      for (int it = 0; it < 24; it++) begin
         n = int'($urandom_range(0, 8));
         s = 32'h2000_1000 + 32'(4 * $urandom_range(0, 31));
         d = 32'h2000_1000 + 32'(4 * $urandom_range(0, 31));
         if ($urandom_range(0, 7) == 0) s[1:0] = 2'($urandom_range(1, 3));
         fw   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 8)) : 0;
         hold = $urandom_range(0, 9) == 0;
         run(s, d, n, fw, hold, $sformatf("rand%0d", it));
      end
      check("proto.idle_zero", idle_bad, 0);
      check("proto.byte_en", be_bad, 0);
      check("proto.done_err", both_bad, 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: got no completion expected finish before time limit");
      $fatal(1, "simulation stuck");
   end
endmodule
